// File: rtl/multiplier_sequential_pkg.sv
// Shared definitions for the sequential arithmetic units (multiplier and divider).
// Holds the handshake state encoding and the SIGNED parameter string constants.
package multiplier_sequential_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    FINISH = 2'd2,
    DONE   = 2'd3
  } seq_state_e;

  localparam string SIGNED_TRUE  = "True";
  localparam string SIGNED_FALSE = "False";

endpackage

// File: rtl/multiplier_sequential_twos_complement_abs.sv
// Two's-complement magnitude/sign extraction with a forced-negate input so the
// same negation path can be reused to apply a sign to an unsigned result.
module twos_complement_abs #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             signed_i,
  input  logic             negate_i,
  output logic [WIDTH-1:0] mag_o,
  output logic             sign_o
);

  assign sign_o = signed_i & data_i[WIDTH-1];
  // Most-negative input maps to 2^(WIDTH-1), which still fits as an unsigned magnitude.
  assign mag_o  = (sign_o | negate_i) ? ('0 - data_i) : data_i;

endmodule

// File: rtl/multiplier_sequential.sv
// Radix-2 shift-add multiplier: one multiplier bit per cycle, full double-width
// product, start/ready_o/valid/ready_i handshake shared with the divider.
module multiplier_sequential
  import multiplier_sequential_pkg::*;
#(
  parameter int unsigned MUL_SIZE = 8,
  parameter string       SIGNED   = SIGNED_FALSE
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  ready_i,
  input  logic [MUL_SIZE-1:0]   multiplicand,
  input  logic [MUL_SIZE-1:0]   multiplier,
  output logic [2*MUL_SIZE-1:0] product,
  output logic                  valid,
  output logic                  ready_o
);

  localparam bit          IS_SIGNED = (SIGNED == SIGNED_TRUE);
  localparam int unsigned PW        = 2 * MUL_SIZE;
  localparam int unsigned CW        = $clog2(MUL_SIZE + 1);

  seq_state_e          state_q, state_d;
  logic [PW:0]         acc_q, acc_d;
  logic [MUL_SIZE-1:0] mcand_q, mcand_d;
  logic [MUL_SIZE-1:0] mplier_q, mplier_d;
  logic [CW-1:0]       count_q, count_d;
  logic                sign_q, sign_d;
  logic [PW-1:0]       product_q, product_d;
  logic                valid_q, valid_d;

  logic [MUL_SIZE-1:0] mag_a, mag_b, addend;
  logic                sign_a, sign_b;
  logic [MUL_SIZE:0]   partial_sum;
  logic [PW-1:0]       fin_value;
  logic                fin_sign_unused;

  twos_complement_abs #(.WIDTH(MUL_SIZE)) u_abs_a (
    .data_i   (multiplicand),
    .signed_i (IS_SIGNED),
    .negate_i (1'b0),
    .mag_o    (mag_a),
    .sign_o   (sign_a)
  );

  twos_complement_abs #(.WIDTH(MUL_SIZE)) u_abs_b (
    .data_i   (multiplier),
    .signed_i (IS_SIGNED),
    .negate_i (1'b0),
    .mag_o    (mag_b),
    .sign_o   (sign_b)
  );

  // Unsigned view of the accumulator, negated when the operand signs differ.
  twos_complement_abs #(.WIDTH(PW)) u_neg_prod (
    .data_i   (acc_q[PW-1:0]),
    .signed_i (1'b0),
    .negate_i (sign_q),
    .mag_o    (fin_value),
    .sign_o   (fin_sign_unused)
  );

  always_comb begin
    addend      = mplier_q[0] ? mcand_q : '0;
    partial_sum = acc_q[PW:MUL_SIZE] + {1'b0, addend};
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    count_d   = count_q;
    sign_d    = sign_q;
    product_d = product_q;
    valid_d   = valid_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = mag_a;
          mplier_d = mag_b;
          sign_d   = sign_a ^ sign_b;
          acc_d    = '0;
          count_d  = CW'(MUL_SIZE);
          state_d  = BUSY;
        end
      end
      BUSY: begin
        acc_d    = {partial_sum, acc_q[MUL_SIZE-1:0]} >> 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        product_d = fin_value;
        valid_d   = 1'b1;
        state_d   = DONE;
      end
      DONE: begin
        if (ready_i) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
      sign_q    <= 1'b0;
      product_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      count_q   <= count_d;
      sign_q    <= sign_d;
      product_q <= product_d;
      valid_q   <= valid_d;
    end
  end

  assign product = product_q;
  assign valid   = valid_q;
  assign ready_o = (state_q == IDLE);

endmodule

// File: tb/tb_multiplier_sequential.sv
// Scoreboard bench: unsigned and signed instances driven in lockstep, results
// checked against integer-arithmetic reference products.
module tb_multiplier_sequential;

  localparam int unsigned N = 8;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic           ready_i;
  logic [N-1:0]   mcand;
  logic [N-1:0]   mplier;
  logic [2*N-1:0] prod_u, prod_s;
  logic           valid_u, valid_s;
  logic           rdy_u, rdy_s;

  multiplier_sequential #(.MUL_SIZE(N), .SIGNED("False")) u_dut_u (
    .clock        (clk),
    .reset        (rst_n),
    .start        (start),
    .ready_i      (ready_i),
    .multiplicand (mcand),
    .multiplier   (mplier),
    .product      (prod_u),
    .valid        (valid_u),
    .ready_o      (rdy_u)
  );

  multiplier_sequential #(.MUL_SIZE(N), .SIGNED("True")) u_dut_s (
    .clock        (clk),
    .reset        (rst_n),
    .start        (start),
    .ready_i      (ready_i),
    .multiplicand (mcand),
    .multiplier   (mplier),
    .product      (prod_s),
    .valid        (valid_s),
    .ready_o      (rdy_s)
  );

  int unsigned ntests = 0;
  int unsigned nfail  = 0;
  int unsigned cycle  = 0;
  bit          rand_ready = 1'b0;
  logic        valid_u_prev = 1'b0;

  logic [2*N-1:0] exp_u[$];
  logic [2*N-1:0] exp_s[$];
  int unsigned    acc_cyc[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      ready_i = 1'($urandom_range(0, 1));
    end
  end

  function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input bit sgn);
    int x, y;
    if (sgn) begin
      x = int'($signed(a));
      y = int'($signed(b));
    end else begin
      x = int'(a);
      y = int'(b);
    end
    return (2*N)'(x * y);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    ntests++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: latency measured on valid rise, results popped on the consuming handshake.
  always @(negedge clk) valid_u_prev <= valid_u;

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_u && !valid_u_prev) begin
        if (acc_cyc.size() == 0) chk("valid_without_accept", 32'(valid_u), 32'd0);
        else chk("latency", cycle - acc_cyc.pop_front(), 32'(N + 1));
      end
      if (valid_u && ready_i) begin
        if (exp_u.size() == 0) chk("spurious_valid_u", 32'(valid_u), 32'd0);
        else chk("product_unsigned", 32'(prod_u), 32'(exp_u.pop_front()));
      end
      if (valid_s && ready_i) begin
        if (exp_s.size() == 0) chk("spurious_valid_s", 32'(valid_s), 32'd0);
        else chk("product_signed", 32'(prod_s), 32'(exp_s.pop_front()));
      end
    end
  end

  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
    int unsigned n = 0;
    while (!rdy_u && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!rdy_u) begin
      chk("issue_timeout", 32'(rdy_u), 32'd1);
      return;
    end
    start  = 1'b1;
    mcand  = a;
    mplier = b;
    exp_u.push_back(ref_mul(a, b, 1'b0));
    exp_s.push_back(ref_mul(a, b, 1'b1));
    acc_cyc.push_back(cycle + 1);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_valid();
    int unsigned n = 0;
    while (!valid_u && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!valid_u) chk("valid_timeout", 32'(valid_u), 32'd1);
  endtask

  task automatic drain();
    int unsigned n = 0;
    while ((exp_u.size() != 0 || exp_s.size() != 0) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_unsigned", 32'(exp_u.size()), 32'd0);
    chk("drain_signed", 32'(exp_s.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] ca[8];
    logic [N-1:0] cb[8];
    logic [2*N-1:0] cap;

    ca = '{8'h00, 8'hFF, 8'h80, 8'hFF, 8'h7F, 8'h00, 8'h01, 8'h80};
    cb = '{8'h00, 8'hFF, 8'h80, 8'h7F, 8'h80, 8'hFB, 8'hFF, 8'h01};

    rst_n   = 1'b0;
    start   = 1'b0;
    ready_i = 1'b1;
    mcand   = '0;
    mplier  = '0;
    #2;
    chk("reset_ready_o", 32'(rdy_u), 32'd1);
    chk("reset_valid", 32'(valid_u), 32'd0);
    chk("reset_product", 32'(prod_u), 32'd0);
    chk("reset_valid_s", 32'(valid_s), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Corner operands, then randomized operands with random consumer backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 8; i++) issue(ca[i], cb[i]);
    for (int i = 0; i < 300; i++) issue(N'($urandom), N'($urandom));
    drain();
    rand_ready = 1'b0;
    @(posedge clk);
    #2;

    // Backpressure: valid and product hold while ready_i is low.
    ready_i = 1'b0;
    issue(8'd200, 8'd13);
    wait_valid();
    cap = prod_u;
    chk("bp_first_product", 32'(cap), 32'd2600);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid_held", 32'(valid_u), 32'd1);
      chk("bp_product_held", 32'(prod_u), 32'(cap));
    end
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_valid_fall", 32'(valid_u), 32'd0);
    chk("bp_ready_rise", 32'(rdy_u), 32'd1);
    chk("bp_product_kept", 32'(prod_u), 32'(cap));
    drain();

    // start held with changing operands during BUSY/FINISH/DONE must be ignored.
    ready_i = 1'b0;
    issue(8'd37, 8'd91);
    start = 1'b1;
    for (int n = 0; n < 50 && !valid_u; n++) begin
      mcand  = N'($urandom);
      mplier = N'($urandom);
      @(posedge clk);
      #1;
      chk("busy_ready_low", 32'(rdy_u), 32'd0);
    end
    if (!valid_u) chk("ignore_valid_timeout", 32'(valid_u), 32'd1);
    repeat (2) begin
      mcand = N'($urandom);
      @(posedge clk);
      #1;
      chk("done_held_with_start", 32'(valid_u), 32'd1);
    end
    start   = 1'b0;
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) @(posedge clk);
    #1;
    chk("no_second_op_ready", 32'(rdy_u), 32'd1);
    chk("no_second_op_valid", 32'(valid_u), 32'd0);
    drain();

    // Asynchronous reset three cycles into BUSY discards the operation.
    issue(8'd3, 8'd7);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_u.delete();
    exp_s.delete();
    acc_cyc.delete();
    #1;
    chk("midreset_valid", 32'(valid_u), 32'd0);
    chk("midreset_product", 32'(prod_u), 32'd0);
    chk("midreset_ready_o", 32'(rdy_u), 32'd1);
    chk("midreset_ready_o_s", 32'(rdy_s), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(8'd6, 8'd7);
    wait_valid();
    chk("post_reset_product", 32'(prod_u), 32'd42);
    drain();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
